// File: rtl/seg_scan_pkg.sv
// rtl/seg_scan_pkg.sv - shared types, segment table and parameter helper for seg_scan_display
package seg_scan_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   // Index 0 holds the code for digit 0; bit0 = segment a ... bit6 = segment g.
   localparam logic [9:0][6:0] SEG7 = {
      7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D,
      7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
   };

   // BCD codes 10..15 cannot come out of the converter; they show nothing.
   function automatic logic [6:0] seg7_decode(input logic [3:0] digit);
      logic [6:0] code;
      code = SEG_BLANK;
      for (int i = 0; i < 10; i++) begin
         if (digit == 4'(i)) code = SEG7[i];
      end
      return code;
   endfunction

   // Smallest d with 10^d >= 2^width, i.e. enough digits for 2^width - 1.
   function automatic int min_digits(input int width);
      logic [255:0] pow2;
      logic [255:0] p10;
      int           d;
      pow2 = 256'd1 << width;
      p10  = 256'd1;
      d    = 0;
      for (int i = 0; i < 78; i++) begin
         if (p10 < pow2) begin
            p10 = p10 * 256'd10;
            d   = d + 1;
         end
      end
      return d;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// rtl/bin2bcd_seq.sv - sequential double-dabble binary to BCD converter with valid/ready input
module bin2bcd_seq
   import seg_scan_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int DIGITS = 3
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     bin_in,
   input  logic                  bin_valid,
   output logic                  bin_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   output logic                  bcd_load,
   output logic [4*DIGITS-1:0]   bcd_next
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int BCD_W = 4 * DIGITS;

   state_t              state;
   state_t              state_nx;
   logic [DATA_W-1:0]   sh_bin;
   logic [BCD_W-1:0]    acc;
   logic [BCD_W-1:0]    acc_adj;
   logic [BCD_W-1:0]    acc_shl;
   logic [CNT_W-1:0]    cnt;
   logic                take;
   logic                last_bit;

   // Add-3 correction on every digit >= 5, then shift the next binary bit in.
   always_comb begin
      acc_adj = acc;
      for (int i = 0; i < DIGITS; i++) begin
         if (acc[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc[4*i +: 4] + 4'd3;
      end
      acc_shl = {acc_adj[BCD_W-2:0], sh_bin[DATA_W-1]};
   end

   assign take      = (state == IDLE) && bin_valid;
   assign last_bit  = (state == SHIFT) && (cnt == CNT_W'(1));
   assign bin_ready = (state == IDLE);
   assign bcd_valid = (state == DONE);
   assign bcd_load  = last_bit;
   assign bcd_next  = acc_shl;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   // Next-state: one accept, DATA_W shifts, one result cycle.
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bin_valid) state_nx = SHIFT;
         SHIFT:   if (last_bit)  state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Shift register, accumulator, bit counter and result register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_bin  <= '0;
         acc     <= '0;
         cnt     <= '0;
         bcd_out <= '0;
      end else if (take) begin
         sh_bin  <= bin_in;
         acc     <= '0;
         cnt     <= CNT_W'(DATA_W);
      end else if (state == SHIFT) begin
         acc     <= acc_shl;
         sh_bin  <= {sh_bin[DATA_W-2:0], 1'b0};
         cnt     <= cnt - CNT_W'(1);
         if (last_bit) bcd_out <= acc_shl;
      end
   end

endmodule

// File: rtl/seg_scan_display.sv
// rtl/seg_scan_display.sv - scanned seven-segment display controller; LZ_BLANK_EN enables leading-zero blanking
module seg_scan_display
   import seg_scan_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int DIGITS   = 3,
   parameter int SCAN_DIV = 1000
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DATA_W-1:0]     bin_in,
   input  logic                  bin_valid,
   output logic                  bin_ready,
   output logic [4*DIGITS-1:0]   bcd_out,
   output logic                  bcd_valid,
   output logic [6:0]            seg,
   output logic [DIGITS-1:0]     dig_sel
);

   localparam int PRE_W = $clog2(SCAN_DIV);
   localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

   if (DATA_W < 4) begin : g_bad_width
      $error("seg_scan_display: DATA_W must be at least 4");
   end
   if (SCAN_DIV < 2) begin : g_bad_div
      $error("seg_scan_display: SCAN_DIV must be at least 2");
   end
   if (DIGITS < min_digits(DATA_W)) begin : g_bad_digits
      $error("seg_scan_display: DIGITS too small to hold 2^DATA_W-1");
   end

   logic                  bcd_load;
   logic [4*DIGITS-1:0]   bcd_next;
   logic [4*DIGITS-1:0]   disp;
   logic [PRE_W-1:0]      pre;
   logic                  pre_wrap;
   logic [IDX_W-1:0]      idx;
   logic [IDX_W-1:0]      idx_nx;
   logic [3:0]            cur_digit;
   logic                  blank;
   logic [6:0]            seg_nx;
   logic [DIGITS-1:0]     sel_nx;

   bin2bcd_seq #(
      .DATA_W (DATA_W),
      .DIGITS (DIGITS)
   ) u_conv (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_in    (bin_in),
      .bin_valid (bin_valid),
      .bin_ready (bin_ready),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .bcd_load  (bcd_load),
      .bcd_next  (bcd_next)
   );

   // Display register follows the converter result on the same edge as bcd_out.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)        disp <= '0;
      else if (bcd_load) disp <= bcd_next;
   end

   assign pre_wrap = (pre == PRE_W'(SCAN_DIV - 1));

   // Prescaler and digit index; free-running, untouched by conversions.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre <= '0;
         idx <= '0;
      end else begin
         pre <= pre_wrap ? '0 : pre + PRE_W'(1);
         idx <= idx_nx;
      end
   end

   // Digit index for the coming cycle and the BCD digit it selects.
   always_comb begin
      idx_nx = idx;
      if (pre_wrap) idx_nx = (idx == IDX_W'(DIGITS - 1)) ? '0 : idx + IDX_W'(1);
      cur_digit = 4'd0;
      for (int i = 0; i < DIGITS; i++) begin
         if (IDX_W'(i) == idx_nx) cur_digit = disp[4*i +: 4];
      end
   end

`ifdef LZ_BLANK_EN
   logic [IDX_W-1:0] msd;

   // Blank every digit above the most significant nonzero one; digit 0 always shows.
   always_comb begin
      msd = '0;
      for (int i = 0; i < DIGITS; i++) begin
         if (disp[4*i +: 4] != 4'd0) msd = IDX_W'(i);
      end
      blank = (idx_nx > msd);
   end
`else
   assign blank = 1'b0;
`endif

   assign seg_nx = blank ? SEG_BLANK : seg7_decode(cur_digit);
   assign sel_nx = DIGITS'(1) << idx_nx;

   // Register select and segments together so they always refer to the same digit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         seg     <= SEG_BLANK;
         dig_sel <= DIGITS'(1);
      end else begin
         seg     <= seg_nx;
         dig_sel <= sel_nx;
      end
   end

endmodule

// File: tb/tb_seg_scan_display.sv
// tb/tb_seg_scan_display.sv - self-checking bench for seg_scan_display (SCAN_DIV=4)
module tb_seg_scan_display;

   localparam int DATA_W   = 8;
   localparam int DIGITS   = 3;
   localparam int SCAN_DIV = 4;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [7:0]    bin_in = '0;
   logic          bin_valid = 1'b0;
   logic          bin_ready;
   logic [11:0]   bcd_out;
   logic          bcd_valid;
   logic [6:0]    seg;
   logic [2:0]    dig_sel;

   int n_checks = 0;
   int n_fail   = 0;
   int segtab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};

   typedef struct {
      int          value;
      logic [11:0] bcd;
   } vec_t;
   vec_t vecs [12];

   seg_scan_display #(
      .DATA_W   (DATA_W),
      .DIGITS   (DIGITS),
      .SCAN_DIV (SCAN_DIV)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bin_in    (bin_in),
      .bin_valid (bin_valid),
      .bin_ready (bin_ready),
      .bcd_out   (bcd_out),
      .bcd_valid (bcd_valid),
      .seg       (seg),
      .dig_sel   (dig_sel)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [11:0] ref_bcd(input int v);
      logic [11:0] r;
      int          p;
      r = '0;
      p = 1;
      for (int i = 0; i < DIGITS; i++) begin
         r[4*i +: 4] = 4'((v / p) % 10);
         p = p * 10;
      end
      return r;
   endfunction

   function automatic logic [6:0] ref_seg(input int v, input int d);
      int p;
      p = 1;
      for (int i = 0; i < d; i++) p = p * 10;
`ifdef LZ_BLANK_EN
      if (d > 0 && v < p) return 7'h00;
`endif
      return 7'(segtab[(v / p) % 10]);
   endfunction

   task automatic convert(input int v, input logic [11:0] exp_bcd);
      int lat;
      int low;
      int pulses;
      lat    = -1;
      low    = 0;
      pulses = 0;
      check("ready_before_accept", bin_ready, 1);
      bin_in    = 8'(v);
      bin_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      bin_valid = 1'b0;
      for (int k = 0; k < 40; k++) begin
         if (bcd_valid) begin
            pulses++;
            if (lat < 0) lat = k;
         end
         if (bin_ready) break;
         low++;
         @(posedge clk);
         @(negedge clk);
      end
      check($sformatf("latency[%0d]", v), lat, DATA_W);
      check($sformatf("busy_cycles[%0d]", v), low, DATA_W + 1);
      check($sformatf("valid_pulses[%0d]", v), pulses, 1);
      check($sformatf("bcd_out[%0d]", v), bcd_out, exp_bcd);
   endtask

   task automatic scan_check(input int v);
      logic [2:0] prev;
      int         last_chg;
      int         d;
      last_chg = -1;
      prev     = dig_sel;
      for (int i = 0; i < 30; i++) begin
         @(posedge clk);
         @(negedge clk);
         check("dig_sel_onehot", 32'($onehot(dig_sel)), 1);
         d = 0;
         for (int j = 0; j < DIGITS; j++) if (dig_sel[j]) d = j;
         check($sformatf("seg[v=%0d,d=%0d]", v, d), seg, ref_seg(v, d));
         if (i > 0 && dig_sel != prev) begin
            check("scan_order", dig_sel, {prev[1:0], prev[2]});
            if (last_chg >= 0) check("scan_hold", i - last_chg, SCAN_DIV);
            last_chg = i;
         end
         prev = dig_sel;
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int v;
      int pulses;
      int gap;
      vecs[0]  = '{0,   12'h000};
      vecs[1]  = '{255, 12'h255};
      vecs[2]  = '{1,   12'h001};
      vecs[3]  = '{7,   12'h007};
      vecs[4]  = '{9,   12'h009};
      vecs[5]  = '{10,  12'h010};
      vecs[6]  = '{99,  12'h099};
      vecs[7]  = '{100, 12'h100};
      vecs[8]  = '{128, 12'h128};
      vecs[9]  = '{200, 12'h200};
      vecs[10] = '{37,  12'h037};
      vecs[11] = '{254, 12'h254};

      // reset state
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_bin_ready", bin_ready, 1);
      check("rst_bcd_out", bcd_out, 0);
      check("rst_bcd_valid", bcd_valid, 0);
      check("rst_dig_sel", dig_sel, 3'b001);
      check("rst_seg", seg, 0);
      rst_n = 1'b1;
      #1;
      check("first_cycle_seg", seg, 0);
      check("first_cycle_dig_sel", dig_sel, 3'b001);
      @(negedge clk);
      check("after_first_clock_seg", seg, 7'h3F);

      // table-driven conversions, scan checks on a few display values
      for (int i = 0; i < 12; i++) begin
         convert(vecs[i].value, vecs[i].bcd);
         if (vecs[i].value == 255 || vecs[i].value == 7 || vecs[i].value == 100)
            scan_check(vecs[i].value);
      end

      // 99 pulsed only while busy is dropped
      bin_in = 8'd37; bin_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bin_valid = 1'b0;
      @(posedge clk); @(posedge clk); @(negedge clk);
      bin_in = 8'd99; bin_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bin_valid = 1'b0;
      pulses = 0;
      for (int k = 0; k < 20; k++) begin
         if (bcd_valid) pulses++;
         @(posedge clk); @(negedge clk);
      end
      check("pulsed_busy_pulses", pulses, 1);
      check("pulsed_busy_bcd", bcd_out, 12'h037);
      check("pulsed_busy_ready", bin_ready, 1);

      // valid held: 99 accepted as soon as ready, back-to-back rate
      bin_in = 8'd37; bin_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bin_in = 8'd99;
      for (int k = 0; k < 40 && !bcd_valid; k++) begin
         @(posedge clk); @(negedge clk);
      end
      check("held_first_bcd", bcd_out, 12'h037);
      gap = 0;
      for (int k = 0; k < 40; k++) begin
         @(posedge clk); @(negedge clk);
         gap++;
         if (gap == 2) bin_valid = 1'b0;
         if (bcd_valid) break;
      end
      bin_valid = 1'b0;
      check("held_gap", gap, DATA_W + 2);
      check("held_second_bcd", bcd_out, 12'h099);
      @(posedge clk); @(negedge clk);

      // reset mid-conversion aborts
      convert(99, 12'h099);
      bin_in = 8'd200; bin_valid = 1'b1;
      @(posedge clk); @(negedge clk);
      bin_valid = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_bcd_out", bcd_out, 0);
      check("abort_ready", bin_ready, 1);
      check("abort_seg", seg, 0);
      check("abort_dig_sel", dig_sel, 3'b001);
      pulses = 0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); @(negedge clk);
         if (bcd_valid) pulses++;
      end
      rst_n = 1'b1;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); @(negedge clk);
         if (bcd_valid) pulses++;
      end
      check("abort_no_valid", pulses, 0);
      check("abort_bcd_after", bcd_out, 0);
      scan_check(0);
      convert(200, 12'h200);

      // randomized values against the arithmetic model
      for (int n = 0; n < 15; n++) begin
         v = int'($urandom_range(0, 255));
         convert(v, ref_bcd(v));
         if (n % 5 == 0) scan_check(v);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
